// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: valid/ready execution unit. Single-cycle ALU ops and
// WIDTH-cycle iterative multiply/divide that share one result register.
//
// state | meaning
// IDLE  | ready for a new request (in_ready=1)
// BUSY  | iterating a multiply/divide; cnt counts down from WIDTH
// DONE  | result presented (out_valid=1), waiting for out_ready
module alu_seq_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2:0]       f3;
  logic             neg;
  logic [WIDTH-1:0] opd;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // single-cycle ALU result from the live operands
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;
  logic             lt_s;
  logic             lt_u;

  // M-op operand conditioning and the early-out special cases
  logic             a_sgn, b_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] special_res;
  logic             neg_acc;

  // one iteration step and the final signed result
  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fin_res;

  // ALU operation decode; unused codes fall to zero
  always_comb begin
    shamt   = src_b[SHW-1:0];
    lt_s    = $signed(src_a) < $signed(src_b);
    lt_u    = src_a < src_b;
    alu_res = '0;
    case (op[3:0])
      4'b0000: alu_res = src_a & src_b;
      4'b0001: alu_res = src_a | src_b;
      4'b0010: alu_res = src_a + src_b;
      4'b0011: alu_res = $signed(src_a) >>> shamt;
      4'b0110: alu_res = src_a - src_b;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, lt_s};
      4'b1000: alu_res = src_a << shamt;
      4'b1001: alu_res = src_a >> shamt;
      4'b1010: alu_res = src_a ^ src_b;
      4'b1011: alu_res = {{(WIDTH-1){1'b0}}, ~lt_s};
      4'b1100: alu_res = ~(src_a | src_b);
      4'b1101: alu_res = {{(WIDTH-1){1'b0}}, ~lt_u};
      4'b1110: alu_res = {{(WIDTH-1){1'b0}}, src_a == src_b};
      4'b1111: alu_res = {{(WIDTH-1){1'b0}}, lt_u};
      default: alu_res = '0;
    endcase
  end

  // operand signedness, magnitudes and divide special cases at accept
  always_comb begin
    if (op[2]) begin
      a_sgn = ~op[0];
      b_sgn = ~op[0];
    end else begin
      a_sgn = ~(op[1] & op[0]);
      b_sgn = ~op[1];
    end
    a_neg       = a_sgn & src_a[WIDTH-1];
    b_neg       = b_sgn & src_b[WIDTH-1];
    a_mag       = a_neg ? -src_a : src_a;
    b_mag       = b_neg ? -src_b : src_b;
    div_zero    = op[2] && (src_b == '0);
    div_ovf     = op[2] && !op[0] && (src_a == MIN_VAL) && (src_b == ONES);
    special_res = div_zero ? (op[1] ? src_a : ONES) : (op[1] ? '0 : MIN_VAL);
    // remainder takes the dividend sign, everything else the product of signs
    neg_acc     = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
  end

  // shift-add / restoring-divide step; final value uses the step outputs
  always_comb begin
    mul_add   = lo[0] ? opd : '0;
    mul_sum   = {1'b0, hi} + {1'b0, mul_add};
    div_shift = {hi, lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opd};
    if (f3[2]) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo[WIDTH-1:1]};
    end
    prod = {step_hi, step_lo};
    if (neg) prod = -prod;
    quo = neg ? -step_lo : step_lo;
    rem = neg ? -step_hi : step_hi;
    case (f3)
      3'b000:                  fin_res = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011:  fin_res = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:          fin_res = quo;
      default:                 fin_res = rem;
    endcase
  end

  // control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      cnt       <= '0;
      f3        <= '0;
      neg       <= 1'b0;
      opd       <= '0;
      hi        <= '0;
      lo        <= '0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (!op[4]) begin
              result    <= alu_res;
              zero      <= (alu_res == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (div_zero || div_ovf) begin
              result    <= special_res;
              zero      <= (special_res == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              f3    <= op[2:0];
              neg   <= neg_acc;
              opd   <= op[2] ? b_mag : a_mag;
              lo    <= op[2] ? a_mag : b_mag;
              hi    <= '0;
              cnt   <= CW'(WIDTH);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result    <= fin_res;
            zero      <= (fin_res == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Scoreboard bench: stimulus pushes expected result/latency, per-DUT
// monitors pop and compare whenever out_valid rises.
module tb_alu_seq_muldiv;

  localparam logic [4:0] AND_ = 5'b00000, OR_  = 5'b00001, ADD  = 5'b00010;
  localparam logic [4:0] SRA  = 5'b00011, U4   = 5'b00100, SUB  = 5'b00110;
  localparam logic [4:0] SLT  = 5'b00111, SLL  = 5'b01000, SRL  = 5'b01001;
  localparam logic [4:0] XOR_ = 5'b01010, GE   = 5'b01011, NOR_ = 5'b01100;
  localparam logic [4:0] GEU  = 5'b01101, EQ   = 5'b01110, SLTU = 5'b01111;
  localparam logic [4:0] MUL  = 5'b10000, MULH = 5'b10001, MULHSU = 5'b10010;
  localparam logic [4:0] MULHU = 5'b10011, DIV = 5'b10100, DIVU = 5'b10101;
  localparam logic [4:0] REM  = 5'b10110, REMU = 5'b10111;
  localparam int L32 = 33;
  localparam int L16 = 17;

  typedef struct {
    logic [31:0] r;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_valid = 1'b0, in_ready, out_valid, zero;
  logic [4:0]  op = '0;
  logic [31:0] src_a = '0, src_b = '0, result;

  logic        in_valid16 = 1'b0, in_ready16, out_valid16, zero16;
  logic [4:0]  op16 = '0;
  logic [15:0] a16 = '0, b16 = '0, result16;

  exp_t q32[$];
  exp_t q16[$];
  exp_t e32, e16;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   acc32 = 0, acc16 = 0;
  logic ov32_d = 1'b0, ov16_d = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_seq_muldiv #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .op(op), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
  );

  alu_seq_muldiv #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid16),
    .in_ready(in_ready16), .op(op16), .src_a(a16), .src_b(b16),
    .out_valid(out_valid16), .out_ready(out_ready), .result(result16), .zero(zero16)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // monitor for the 32-bit unit
  always @(negedge clk) begin
    if (in_valid && in_ready && !flush && rst_n) acc32 = cyc;
    if (out_valid && !ov32_d) begin
      if (q32.size() == 0) begin
        chk("unexpected_out_valid32", 32'd1, 32'd0);
      end else begin
        e32 = q32.pop_front();
        chk("result32", result, e32.r);
        chk("zero32", {31'd0, zero}, {31'd0, e32.r == 32'd0});
        chk("latency32", cyc - acc32, e32.lat);
      end
    end
    ov32_d = out_valid;
  end

  // monitor for the 16-bit unit
  always @(negedge clk) begin
    if (in_valid16 && in_ready16 && !flush && rst_n) acc16 = cyc;
    if (out_valid16 && !ov16_d) begin
      if (q16.size() == 0) begin
        chk("unexpected_out_valid16", 32'd1, 32'd0);
      end else begin
        e16 = q16.pop_front();
        chk("result16", {16'd0, result16}, {16'd0, e16.r[15:0]});
        chk("zero16", {31'd0, zero16}, {31'd0, e16.r[15:0] == 16'd0});
        chk("latency16", cyc - acc16, e16.lat);
      end
    end
    ov16_d = out_valid16;
  end

  // called at posedge+1; returns at posedge+1 just after the accept edge
  task automatic issue(input bit w16, input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r, input int lat,
                       input bit push);
    exp_t e;
    int n;
    e.r = r;
    e.lat = lat;
    n = 0;
    while (!(w16 ? in_ready16 : in_ready) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("in_ready_timeout", 32'd0, 32'd1);
    if (push) begin
      if (w16) q16.push_back(e);
      else q32.push_back(e);
    end
    if (w16) begin
      op16 = o; a16 = a[15:0]; b16 = b[15:0]; in_valid16 = 1'b1;
    end else begin
      op = o; src_a = a; src_b = b; in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_valid16 = 1'b0;
  endtask

  // wait for the scoreboard to drain; in_ready must stay low meanwhile
  task automatic drain(input bit w16);
    int n;
    bit bad;
    n = 0;
    bad = 1'b0;
    while ((w16 ? q16.size() : q32.size()) != 0 && n < 100) begin
      if (w16 ? in_ready16 : in_ready) bad = 1'b1;
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("result_timeout", 32'd0, 32'd1);
    chk("in_ready_low_while_pending", {31'd0, bad}, 32'd0);
  endtask

  task automatic run(input bit w16, input logic [4:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] r, input int lat);
    issue(w16, o, a, b, r, lat, 1'b1);
    drain(w16);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_zero", {31'd0, zero}, 32'd1);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_in_ready16", {31'd0, in_ready16}, 32'd1);

    // ALU sweep
    run(0, ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1);
    run(0, SUB,  32'd5,        32'd5,        32'd0,        1);
    run(0, SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        1);
    run(0, SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        1);
    run(0, SRA,  32'h80000000, 32'd4,        32'hF8000000, 1);
    run(0, GE,   32'hFFFFFFFF, 32'd1,        32'd0,        1);
    run(0, GEU,  32'hFFFFFFFF, 32'd1,        32'd1,        1);
    run(0, U4,   32'h1234,     32'd5,        32'd0,        1);
    run(0, AND_, 32'hF0F0,     32'hFF00,     32'hF000,     1);
    run(0, OR_,  32'hF0F0,     32'hFF00,     32'hFFF0,     1);
    run(0, XOR_, 32'hF0F0,     32'hFF00,     32'h0FF0,     1);
    run(0, NOR_, 32'd0,        32'd0,        32'hFFFFFFFF, 1);
    run(0, SLL,  32'd1,        32'h21,       32'd2,        1);
    run(0, SRL,  32'h80000000, 32'd31,       32'd1,        1);
    run(0, EQ,   32'd5,        32'd5,        32'd1,        1);

    // multiply
    run(0, MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, L32);
    run(0, MULH,   32'h80000000, 32'h80000000, 32'h40000000, L32);
    run(0, MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, L32);
    run(0, MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, L32);
    run(0, MUL,    32'h10000,    32'h10000,    32'd0,        L32);

    // divide, including the early-out cases
    run(0, DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, L32);
    run(0, REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, L32);
    run(0, DIVU, 32'd100,      32'd7,        32'd14,       L32);
    run(0, REMU, 32'd100,      32'd7,        32'd2,        L32);
    run(0, DIV,  32'd123,      32'd0,        32'hFFFFFFFF, 1);
    run(0, REMU, 32'd123,      32'd0,        32'd123,      1);
    run(0, REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    run(0, DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);

    // backpressure on a completed divide
    out_ready = 1'b0;
    run(0, DIV, 32'd100, 32'd7, 32'd14, L32);
    repeat (10) begin
      @(posedge clk); #1;
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result", result, 32'd14);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    run(0, XOR_, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1);

    // flush in the middle of a MULHU
    issue(0, MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, L32, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (40) begin @(posedge clk); #1; end
    run(0, ADD, 32'd2, 32'd3, 32'd5, 1);

    // asynchronous reset in the middle of a DIV
    issue(0, DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, L32, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    q32.delete();
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_result", result, 32'd0);
    chk("midreset_zero", {31'd0, zero}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postreset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("postreset_out_valid", {31'd0, out_valid}, 32'd0);

    // 16-bit unit
    run(1, MUL,    32'h7,    32'hFFFD, 32'hFFEB, L16);
    run(1, MULH,   32'h8000, 32'h8000, 32'h4000, L16);
    run(1, MULHU,  32'hFFFF, 32'hFFFF, 32'hFFFE, L16);
    run(1, MULHSU, 32'hFFFF, 32'd2,    32'hFFFF, L16);
    run(1, DIV,    32'hFFF9, 32'd2,    32'hFFFD, L16);
    run(1, REM,    32'hFFF9, 32'd2,    32'hFFFF, L16);
    run(1, DIVU,   32'd100,  32'd7,    32'd14,   L16);
    run(1, REMU,   32'd100,  32'd7,    32'd2,    L16);
    run(1, DIV,    32'd55,   32'd0,    32'hFFFF, 1);
    run(1, REM,    32'h8000, 32'hFFFF, 32'd0,    1);

    repeat (5) begin @(posedge clk); #1; end
    chk("queue32_empty", q32.size(), 32'd0);
    chk("queue16_empty", q16.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
